// File: rtl/uart_printer_pkg.sv
// Shared types, ASCII codes and helpers for the UART hex line printer.
package uart_printer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_ISSUE,
        ST_WAIT
    } state_e;

    typedef enum logic [2:0] {
        PH_FLAG,
        PH_FLAGSP,
        PH_DIGIT,
        PH_SEP,
        PH_WORDSP,
        PH_CR,
        PH_LF
    } phase_e;

    localparam logic [7:0] ASCII_SP = 8'h20;
    localparam logic [7:0] ASCII_US = 8'h5F;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_R  = 8'h52;
    localparam logic [7:0] ASCII_W  = 8'h57;

    function automatic logic [7:0] hex2ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

    // Characters in one printed line, including the CR/LF terminator.
    function automatic int unsigned line_len(input int unsigned words,
                                             input int unsigned word_w,
                                             input int unsigned group,
                                             input int unsigned flag_en,
                                             input int unsigned lf_en);
        int unsigned nib;
        int unsigned sep;
        nib = word_w / 4;
        sep = (group != 0 && group < nib) ? (nib - 1) / group : 0;
        return 2 * flag_en + words * (nib + sep) + (words - 1) + 1 + lf_en;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter; tx_busy rises the cycle after an accepted start for 10 bit periods.
module uart_tx #(
    parameter int unsigned CLK_HZ = 100_000_000,
    parameter int unsigned BAUD   = 115200
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       tx_start,
    input  logic [7:0] tx_char,
    output logic       tx_busy,
    output logic       txd
);

    localparam int unsigned DIV   = CLK_HZ / BAUD;
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [DIV_W-1:0] baud_q;
    logic [3:0]       bit_q;
    logic [8:0]       sh_q;
    logic             busy_q;
    logic             txd_q;

    // Start bit goes out on acceptance; sh_q holds data bits then the stop bit.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            baud_q <= '0;
            bit_q  <= '0;
            sh_q   <= '1;
            busy_q <= 1'b0;
            txd_q  <= 1'b1;
        end else if (!busy_q) begin
            if (tx_start) begin
                busy_q <= 1'b1;
                txd_q  <= 1'b0;
                sh_q   <= {1'b1, tx_char};
                baud_q <= '0;
                bit_q  <= '0;
            end
        end else if (baud_q == DIV_W'(DIV - 1)) begin
            baud_q <= '0;
            if (bit_q == 4'd9) begin
                busy_q <= 1'b0;
                txd_q  <= 1'b1;
            end else begin
                txd_q <= sh_q[0];
                sh_q  <= {1'b1, sh_q[8:1]};
                bit_q <= bit_q + 4'd1;
            end
        end else begin
            baud_q <= baud_q + DIV_W'(1);
        end
    end

    assign tx_busy = busy_q;
    assign txd     = txd_q;

endmodule

// File: rtl/uart_hex_printer.sv
// Pops one record from a FIFO and prints it as an uppercase hex ASCII line over UART.
module uart_hex_printer
    import uart_printer_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned BAUD    = 115200,
    parameter int unsigned WORDS   = 2,
    parameter int unsigned WORD_W  = 32,
    parameter int unsigned GROUP   = 4,
    parameter int unsigned FLAG_EN = 1,
    parameter int unsigned LF_EN   = 1
) (
    input  logic                      clk,
    input  logic                      anrst,
    input  logic                      empty,
    output logic                      r_req,
    input  logic                      r_flag,
    input  logic [WORDS*WORD_W-1:0]   r_data,
    output logic                      busy,
    output logic                      uart_txd
);

    localparam int unsigned NIB      = WORD_W / 4;
    localparam int unsigned DATA_W   = WORDS * WORD_W;
    localparam int unsigned IDX_W    = $clog2(DATA_W);
    localparam int unsigned WIDX_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned NIDX_W   = (NIB > 1) ? $clog2(NIB) : 1;
    localparam int unsigned GRP_W    = NIDX_W + 1;
    localparam bit          GRP_EN   = (GROUP != 0) && (GROUP < NIB);
    localparam int unsigned GRP_LAST = GRP_EN ? GROUP - 1 : 0;

    if ((WORD_W % 4) != 0 || WORD_W < 4 || WORD_W > 64) begin : g_bad_word_w
        $error("uart_hex_printer: WORD_W must be a multiple of 4 in 4..64");
    end
    if (WORDS < 1 || WORDS > 16) begin : g_bad_words
        $error("uart_hex_printer: WORDS must be in 1..16");
    end
    if (BAUD > CLK_HZ / 2) begin : g_bad_baud
        $error("uart_hex_printer: BAUD must not exceed CLK_HZ/2");
    end

    state_e              state_q, state_d;
    phase_e              phase_q, phase_d;
    logic [WIDX_W-1:0]   word_q,  word_d;
    logic [NIDX_W-1:0]   nib_q,   nib_d;
    logic [GRP_W-1:0]    grp_q,   grp_d;
    logic                last_q,  last_d;
    logic                seen_q,  seen_d;
    logic                flag_q,  flag_d;
    logic [DATA_W-1:0]   data_q,  data_d;
    logic                r_req_q;
    logic                busy_q;

    logic                tx_start_c;
    logic [7:0]          tx_char_c;
    logic                tx_busy;
    logic [IDX_W-1:0]    nib_lsb_c;
    logic [3:0]          nib_c;

    always_ff @(posedge clk or negedge anrst) begin
        if (!anrst) begin
            state_q <= ST_IDLE;
            phase_q <= PH_FLAG;
            word_q  <= '0;
            nib_q   <= '0;
            grp_q   <= '0;
            last_q  <= 1'b0;
            seen_q  <= 1'b0;
            flag_q  <= 1'b0;
            data_q  <= '0;
            r_req_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            word_q  <= word_d;
            nib_q   <= nib_d;
            grp_q   <= grp_d;
            last_q  <= last_d;
            seen_q  <= seen_d;
            flag_q  <= flag_d;
            data_q  <= data_d;
            r_req_q <= (state_d == ST_CAPTURE);
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    // Next state; counters step to the following character as the current one is issued.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        word_d     = word_q;
        nib_d      = nib_q;
        grp_d      = grp_q;
        last_d     = last_q;
        seen_d     = seen_q;
        flag_d     = flag_q;
        data_d     = data_q;
        tx_start_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!empty && !tx_busy) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                flag_d  = r_flag;
                data_d  = r_data;
                phase_d = (FLAG_EN != 0) ? PH_FLAG : PH_DIGIT;
                word_d  = '0;
                nib_d   = NIDX_W'(NIB - 1);
                grp_d   = '0;
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                tx_start_c = 1'b1;
                seen_d     = 1'b0;
                last_d     = 1'b0;
                state_d    = ST_WAIT;
                case (phase_q)
                    PH_FLAG:   phase_d = PH_FLAGSP;
                    PH_FLAGSP: phase_d = PH_DIGIT;
                    PH_DIGIT: begin
                        if (nib_q == '0) begin
                            grp_d = '0;
                            if (word_q == WIDX_W'(WORDS - 1)) begin
                                phase_d = PH_CR;
                            end else begin
                                phase_d = PH_WORDSP;
                                word_d  = word_q + WIDX_W'(1);
                                nib_d   = NIDX_W'(NIB - 1);
                            end
                        end else begin
                            nib_d = nib_q - NIDX_W'(1);
                            if (GRP_EN && grp_q == GRP_W'(GRP_LAST)) begin
                                grp_d   = '0;
                                phase_d = PH_SEP;
                            end else begin
                                grp_d = grp_q + GRP_W'(1);
                            end
                        end
                    end
                    PH_SEP:    phase_d = PH_DIGIT;
                    PH_WORDSP: phase_d = PH_DIGIT;
                    PH_CR: begin
                        if (LF_EN != 0) begin
                            phase_d = PH_LF;
                        end else begin
                            last_d = 1'b1;
                        end
                    end
                    default:   last_d = 1'b1;
                endcase
            end
            ST_WAIT: begin
                if (tx_busy) begin
                    seen_d = 1'b1;
                end else if (seen_q) begin
                    state_d = last_q ? ST_IDLE : ST_ISSUE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Word 0 sits in the MSBs; nibble index counts down from the word's top nibble.
    always_comb begin
        nib_lsb_c = IDX_W'((WORDS - 1 - 32'(word_q)) * WORD_W + 4 * 32'(nib_q));
        nib_c     = data_q[nib_lsb_c +: 4];
        case (phase_q)
            PH_FLAG:   tx_char_c = flag_q ? ASCII_R : ASCII_W;
            PH_DIGIT:  tx_char_c = hex2ascii(nib_c);
            PH_SEP:    tx_char_c = ASCII_US;
            PH_CR:     tx_char_c = ASCII_CR;
            PH_LF:     tx_char_c = ASCII_LF;
            default:   tx_char_c = ASCII_SP;
        endcase
    end

    uart_tx #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_uart_tx (
        .clk      (clk),
        .nrst     (anrst),
        .tx_start (tx_start_c),
        .tx_char  (tx_char_c),
        .tx_busy  (tx_busy),
        .txd      (uart_txd)
    );

    assign r_req = r_req_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_uart_hex_printer.sv
// Bench for uart_hex_printer: three configurations, UART decoders and a string-level line model.
module tb_uart_hex_printer;
    import uart_printer_pkg::*;

    localparam int unsigned CLK_HZ = 400;
    localparam int unsigned BAUD   = 100;
    localparam int          BIT    = 4;

    typedef byte unsigned bq_t[$];

    logic clk   = 1'b0;
    logic anrst = 1'b1;
    logic rx_en = 1'b0;

    logic        e0 = 1'b1, f0 = 1'b0; logic [63:0] d0 = '0; logic q0, b0, t0;
    logic        e1 = 1'b1, f1 = 1'b0; logic [23:0] d1 = '0; logic q1, b1, t1;
    logic        e2 = 1'b1, f2 = 1'b0; logic [23:0] d2 = '0; logic q2, b2, t2;

    int unsigned cfg_words[3] = '{2, 3, 2};
    int unsigned cfg_ww[3]    = '{32, 8, 12};
    int unsigned cfg_grp[3]   = '{4, 0, 2};
    int unsigned cfg_flag[3]  = '{1, 0, 1};
    int unsigned cfg_lf[3]    = '{1, 0, 1};

    int n_checks = 0;
    int n_errors = 0;
    int req_cnt[3] = '{0, 0, 0};
    int falls0 = 0;
    int gap_err0 = 0;
    logic bprev0 = 1'b0;
    bq_t rx0, rx1, rx2;

    always #5 clk = ~clk;

    uart_hex_printer #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_dut0 (
        .clk(clk), .anrst(anrst), .empty(e0), .r_req(q0), .r_flag(f0),
        .r_data(d0), .busy(b0), .uart_txd(t0));

    uart_hex_printer #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .WORDS(3), .WORD_W(8), .GROUP(0),
                       .FLAG_EN(0), .LF_EN(0)) u_dut1 (
        .clk(clk), .anrst(anrst), .empty(e1), .r_req(q1), .r_flag(f1),
        .r_data(d1), .busy(b1), .uart_txd(t1));

    uart_hex_printer #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .WORDS(2), .WORD_W(12), .GROUP(2)) u_dut2 (
        .clk(clk), .anrst(anrst), .empty(e2), .r_req(q2), .r_flag(f2),
        .r_data(d2), .busy(b2), .uart_txd(t2));

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic req_of(input int inst);
        return (inst == 0) ? q0 : (inst == 1) ? q1 : q2;
    endfunction
    function automatic logic busy_of(input int inst);
        return (inst == 0) ? b0 : (inst == 1) ? b1 : b2;
    endfunction
    function automatic logic txd_of(input int inst);
        return (inst == 0) ? t0 : (inst == 1) ? t1 : t2;
    endfunction

    task automatic drive(input int inst, input logic e, input logic f, input logic [127:0] d);
        case (inst)
            0: begin e0 = e; f0 = f; d0 = 64'(d); end
            1: begin e1 = e; f1 = f; d1 = 24'(d); end
            default: begin e2 = e; f2 = f; d2 = 24'(d); end
        endcase
    endtask

    task automatic rx_push(input int inst, input byte unsigned b);
        case (inst)
            0: rx0.push_back(b);
            1: rx1.push_back(b);
            default: rx2.push_back(b);
        endcase
    endtask
    function automatic int rx_size(input int inst);
        return (inst == 0) ? rx0.size() : (inst == 1) ? rx1.size() : rx2.size();
    endfunction
    function automatic byte unsigned rx_at(input int inst, input int i);
        return (inst == 0) ? rx0[i] : (inst == 1) ? rx1[i] : rx2[i];
    endfunction
    task automatic rx_clear_all();
        rx0.delete(); rx1.delete(); rx2.delete();
    endtask

    // Reference line built directly from the textual line format.
    function automatic bq_t fmt_line(input logic flag, input logic [127:0] data, input int inst);
        bq_t q;
        int  words, word_w, nib_n, group, d;
        logic [63:0] w;
        bit  grp;
        words  = int'(cfg_words[inst]);
        word_w = int'(cfg_ww[inst]);
        group  = int'(cfg_grp[inst]);
        nib_n  = word_w / 4;
        grp    = (group != 0) && (group < nib_n);
        if (cfg_flag[inst] != 0) begin
            q.push_back(flag ? 8'h52 : 8'h57);
            q.push_back(8'h20);
        end
        for (int k = 0; k < words; k++) begin
            if (k > 0) q.push_back(8'h20);
            w = 64'(data >> ((words - 1 - k) * word_w));
            for (int i = nib_n - 1; i >= 0; i--) begin
                d = int'((w >> (4 * i)) & 64'hF);
                q.push_back(8'((d < 10) ? 48 + d : 55 + d));
                if (grp && i != 0 && ((nib_n - i) % group) == 0) q.push_back(8'h5F);
            end
        end
        q.push_back(8'h0D);
        if (cfg_lf[inst] != 0) q.push_back(8'h0A);
        return q;
    endfunction

    function automatic bq_t str2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    function automatic logic [127:0] rand_data(input int inst);
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r & ((128'(1) << (cfg_words[inst] * cfg_ww[inst])) - 128'(1));
    endfunction

    task automatic rx_decode(input int inst);
        logic [7:0] b;
        logic       stop;
        wait (rx_en);
        forever begin
            @(negedge clk);
            if (txd_of(inst) == 1'b0) begin
                repeat (BIT / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT) @(negedge clk);
                    b[i] = txd_of(inst);
                end
                repeat (BIT) @(negedge clk);
                stop = txd_of(inst);
                check_eq($sformatf("stop_bit%0d", inst), 64'(stop), 64'd1);
                rx_push(inst, b);
            end
        end
    endtask

    initial rx_decode(0);
    initial rx_decode(1);
    initial rx_decode(2);

    always @(negedge clk) begin
        if (q0) req_cnt[0]++;
        if (q1) req_cnt[1]++;
        if (q2) req_cnt[2]++;
        if (q0 && bprev0) gap_err0++;
        if (bprev0 && !b0) falls0++;
        bprev0 = b0;
    end

    task automatic wait_req(input int inst, input int bound, output int cyc);
        cyc = -1;
        for (int c = 0; c < bound; c++) begin
            @(negedge clk);
            if (req_of(inst)) begin
                cyc = c;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int inst, input int bound, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < bound; c++) begin
            @(negedge clk);
            if (!busy_of(inst)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic compare_line(input int inst, input bq_t exp, input string tag);
        int n, m, idx;
        n = rx_size(inst);
        check_eq({tag, "_len"}, 64'(n), 64'(exp.size()));
        m   = (n < exp.size()) ? n : exp.size();
        idx = m - 1;
        for (int i = 0; i < m; i++) begin
            if (rx_at(inst, i) != exp[i]) begin
                idx = i;
                break;
            end
        end
        if (m > 0) check_eq($sformatf("%s_char%0d", tag, idx), 64'(rx_at(inst, idx)), 64'(exp[idx]));
    endtask

    task automatic run_line(input int inst, input logic flag, input logic [127:0] data,
                            input bq_t exp, input string tag);
        int cyc, base;
        bit ok;
        rx_clear_all();
        base = req_cnt[inst];
        @(negedge clk);
        drive(inst, 1'b0, flag, data);
        wait_req(inst, 20, cyc);
        check_eq({tag, "_req_latency"}, 64'(cyc), 64'd0);
        check_eq({tag, "_busy_on"}, 64'(busy_of(inst)), 64'd1);
        @(negedge clk);
        drive(inst, 1'b1, ~flag, {$urandom, $urandom, $urandom, $urandom});
        check_eq({tag, "_req_pulse"}, 64'(req_of(inst)), 64'd0);
        wait_idle(inst, 40 * BIT * 32, ok);
        check_eq({tag, "_busy_off"}, 64'(ok), 64'd1);
        repeat (BIT) @(negedge clk);
        compare_line(inst, exp, tag);
        check_eq({tag, "_len_pkg"}, 64'(rx_size(inst)),
                 64'(line_len(cfg_words[inst], cfg_ww[inst], cfg_grp[inst], cfg_flag[inst], cfg_lf[inst])));
        check_eq({tag, "_pops"}, 64'(req_cnt[inst] - base), 64'd1);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic         f;
        logic [127:0] d;
        logic         bf[4];
        logic [127:0] bd[4];
        bq_t          exp;
        int           cyc, base_req, base_falls, base_gap, cnt_req, cnt_tx, cnt_busy;
        bit           ok;

        #2 anrst = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("rst_req%0d", i),  64'(req_of(i)),  64'd0);
            check_eq($sformatf("rst_busy%0d", i), 64'(busy_of(i)), 64'd0);
            check_eq($sformatf("rst_txd%0d", i),  64'(txd_of(i)),  64'd1);
        end
        @(negedge clk);
        anrst = 1'b1;
        rx_en = 1'b1;
        repeat (3) @(negedge clk);

        run_line(0, 1'b1, 128'h1234ABCD_000000FF, str2q("R 1234_ABCD 0000_00FF\r\n"), "dflt");
        run_line(1, 1'b0, 128'hA50FFF, str2q("A5 0F FF\r"), "cfg2");
        run_line(2, 1'b0, 128'hABC123, str2q("W AB_C 12_3\r\n"), "cfg3");

        for (int inst = 0; inst < 3; inst++) begin
            for (int r = 0; r < 3; r++) begin
                f = 1'($urandom);
                d = rand_data(inst);
                run_line(inst, f, d, fmt_line(f, d, inst), $sformatf("rnd%0d_%0d", inst, r));
            end
        end

        // Four queued records with empty held low between pops.
        exp = {};
        for (int r = 0; r < 4; r++) begin
            bf[r] = 1'($urandom);
            bd[r] = rand_data(0);
            exp = {exp, fmt_line(bf[r], bd[r], 0)};
        end
        rx_clear_all();
        base_req   = req_cnt[0];
        base_falls = falls0;
        base_gap   = gap_err0;
        for (int r = 0; r < 4; r++) begin
            @(negedge clk);
            drive(0, 1'b0, bf[r], bd[r]);
            wait_req(0, 3000, cyc);
            check_eq($sformatf("b2b_req_seen%0d", r), 64'(cyc >= 0), 64'd1);
            @(negedge clk);
            drive(0, (r == 3), ~bf[r], {$urandom, $urandom, $urandom, $urandom});
        end
        wait_idle(0, 3000, ok);
        check_eq("b2b_busy_off", 64'(ok), 64'd1);
        repeat (BIT) @(negedge clk);
        compare_line(0, exp, "b2b");
        check_eq("b2b_pops", 64'(req_cnt[0] - base_req), 64'd4);
        check_eq("b2b_lines", 64'(falls0 - base_falls), 64'd4);
        check_eq("b2b_gap", 64'(gap_err0 - base_gap), 64'd0);

        // Reset during the fifth character.
        rx_clear_all();
        @(negedge clk);
        drive(0, 1'b0, 1'b1, rand_data(0));
        wait_req(0, 20, cyc);
        check_eq("rst_line_req", 64'(cyc), 64'd0);
        @(negedge clk);
        drive(0, 1'b1, 1'b0, rand_data(0));
        for (int c = 0; c < 2000 && rx_size(0) < 4; c++) @(negedge clk);
        check_eq("rst_four_chars", 64'(rx_size(0) >= 4), 64'd1);
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (!t0) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("rst_fifth_start", 64'(ok), 64'd1);
        repeat (3 * BIT) @(negedge clk);
        #2 anrst = 1'b0;
        #1;
        check_eq("rst_mid_txd", 64'(t0), 64'd1);
        check_eq("rst_mid_req", 64'(q0), 64'd0);
        check_eq("rst_mid_busy", 64'(b0), 64'd0);
        repeat (12 * BIT) @(negedge clk);
        rx_clear_all();
        base_req = req_cnt[0];
        anrst = 1'b1;
        repeat (40) @(negedge clk);
        check_eq("rst_no_replay", 64'(req_cnt[0] - base_req), 64'd0);
        check_eq("rst_idle_txd", 64'(t0), 64'd1);
        f = 1'($urandom);
        d = rand_data(0);
        run_line(0, f, d, fmt_line(f, d, 0), "post_rst");

        // Empty source for a long stretch.
        drive(0, 1'b1, 1'b1, rand_data(0));
        drive(1, 1'b1, 1'b1, rand_data(1));
        drive(2, 1'b1, 1'b1, rand_data(2));
        cnt_req = 0;
        cnt_tx = 0;
        cnt_busy = 0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            if (q0 || q1 || q2) cnt_req++;
            if (!(t0 && t1 && t2)) cnt_tx++;
            if (b0 || b1 || b2) cnt_busy++;
            if ((c % 1000) == 0) begin
                d0 = {$urandom, $urandom};
                f0 = ~f0;
            end
        end
        check_eq("idle_req", 64'(cnt_req), 64'd0);
        check_eq("idle_txd", 64'(cnt_tx), 64'd0);
        check_eq("idle_busy", 64'(cnt_busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
